rr_arbiter8way16: RTL and testbench

Round-robin arbiter and sequencer for the 8-way 16-bit selector datapath. It shares one 16-bit output channel between eight requesters by driving the 3-bit select of an 8-way 16-bit mux. Each grant moves one word through a valid/ready handshake and returns a one-cycle acknowledge to the winning requester. It sits between the eight word sources (register/ALU feeders) and a single downstream consumer.

---
 rtl/rr_arbiter8way16_pkg.sv | 22 ++
 rtl/rr_arbiter8way16_mux.sv | 29 ++
 rtl/rr_arbiter8way16_pick8.sv | 27 ++
 rtl/rr_arbiter8way16.sv | 133 +++++++++++++
 tb/tb_rr_arbiter8way16.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/rr_arbiter8way16_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
// The burst option (ARB_BURST_EN) uses BURST_LEN_C as its default length.
package rr_arbiter8way16_pkg;

    localparam int N_REQ_C     = 8;
    localparam int WIDTH_C     = 16;
    localparam int BURST_LEN_C = 4;
    localparam int SEL_W_C     = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic [N_REQ_C-1:0] onehot8(input logic [SEL_W_C-1:0] i);
        logic [N_REQ_C-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter8way16_mux.sv
// 8-way 16-bit word selector driven by a 3-bit select.
module Mux8Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        unique case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
        endcase
    end

endmodule

// File: rtl/rr_arbiter8way16_pick8.sv
// Rotating priority pick: first set request at or above ptr, wrapping 7->0.
module rr_pick8
    import rr_arbiter8way16_pkg::*;
(
    input  logic [N_REQ_C-1:0] req_i,
    input  logic [SEL_W_C-1:0] ptr_i,
    output logic [SEL_W_C-1:0] idx_o,
    output logic               any_o
);

    logic [SEL_W_C-1:0] cand;

    // Walk offsets high to low so the lowest offset from ptr wins last.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int k = N_REQ_C - 1; k >= 0; k--) begin
            cand = ptr_i + SEL_W_C'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/rr_arbiter8way16.sv
// Round-robin arbiter/sequencer sharing one 16-bit channel among 8 requesters.
// Define ARB_BURST_EN to allow up to BURST_LEN back-to-back words per grant.
module rr_arbiter8way16
    import rr_arbiter8way16_pkg::*;
#(
    parameter int N_REQ     = N_REQ_C,
    parameter int WIDTH     = WIDTH_C
`ifdef ARB_BURST_EN
    ,
    parameter int BURST_LEN = BURST_LEN_C
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W_C-1:0]     sel,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack
);

    state_e             state_q, state_d;
    logic [SEL_W_C-1:0] ptr_q, ptr_d;
    logic [SEL_W_C-1:0] sel_q, sel_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [SEL_W_C-1:0] pick_idx;
    logic               pick_any;
    logic               keep;
    logic [WIDTH-1:0]   word [N_REQ];

`ifdef ARB_BURST_EN
    logic [2:0] cnt_q, cnt_d;
`endif

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign word[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_pick8 u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    Mux8Way16 u_mux (
        .a   (word[0]),
        .b   (word[1]),
        .c   (word[2]),
        .d   (word[3]),
        .e   (word[4]),
        .f   (word[5]),
        .g   (word[6]),
        .h   (word[7]),
        .sel (sel_q),
        .out (out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
`ifdef ARB_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
`ifdef ARB_BURST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ack_d   = '0;
        keep    = 1'b0;
`ifdef ARB_BURST_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    grant_d = onehot8(pick_idx);
                    state_d = ST_BUSY;
`ifdef ARB_BURST_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (out_ready) begin
                    ack_d = onehot8(sel_q);
`ifdef ARB_BURST_EN
                    // Words moved including this one must stay below BURST_LEN.
                    if (req[sel_q] &&
                        (({1'b0, cnt_q} + 4'd1) < 4'(BURST_LEN))) begin
                        keep  = 1'b1;
                        cnt_d = cnt_q + 3'd1;
                    end
`endif
                    if (!keep) begin
                        ptr_d   = sel_q + 3'd1;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = (state_q == ST_BUSY);
    assign sel       = sel_q;
    assign grant     = grant_q;
    assign ack       = ack_q;

endmodule

// File: tb/tb_rr_arbiter8way16.sv
// Directed table-driven bench for rr_arbiter8way16 (default build).
module tb_rr_arbiter8way16;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] in_data;
    logic [15:0]  out;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   sel;
    logic [7:0]   grant;
    logic [7:0]   ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] e_grant;
        logic [7:0] e_ack;
        logic       e_valid;
        logic [2:0] e_sel;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] words [8];

    rr_arbiter8way16 dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic r, input logic [7:0] rq,
                       input logic rd, input logic [7:0] g, input logic [7:0] a,
                       input logic v, input logic [2:0] s);
        vec_t t;
        t.name = nm; t.rst = r; t.req = rq; t.rdy = rd;
        t.e_grant = g; t.e_ack = a; t.e_valid = v; t.e_sel = s;
        tbl.push_back(t);
    endtask

    initial begin
        logic [7:0] oh;
        int         nacks;
        int         exp_idx;
        logic [7:0] exp_ack;

        for (int i = 0; i < 8; i++) begin
            words[i] = 16'h1000 * 16'(i) + 16'h0A5C;
        end
        words[5] = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            in_data[i*16 +: 16] = words[i];
        end

        add("rst0", 1, 8'hFF, 1, 8'h00, 8'h00, 0, 0);
        add("rst1", 1, 8'hFF, 1, 8'h00, 8'h00, 0, 0);
        add("rel",  0, 8'hFF, 1, 8'h01, 8'h00, 1, 0);
        add("rr_ack", 0, 8'hFF, 1, 8'h00, 8'h01, 0, 0);
        for (int i = 1; i < 8; i++) begin
            oh = 8'h01 << i;
            add("rr_gnt", 0, 8'hFF, 1, oh, 8'h00, 1, 3'(i));
            add("rr_ack", 0, 8'hFF, 1, 8'h00, oh, 0, 3'(i));
        end
        add("rr_wrap", 0, 8'hFF, 1, 8'h01, 8'h00, 1, 0);
        add("rr_wack", 0, 8'hFF, 1, 8'h00, 8'h01, 0, 0);
        add("s_gnt",   0, 8'h20, 1, 8'h20, 8'h00, 1, 5);
        add("s_ack",   0, 8'h20, 1, 8'h00, 8'h20, 0, 5);
        add("s_regnt", 0, 8'h20, 1, 8'h20, 8'h00, 1, 5);
        add("s_ack2",  0, 8'h20, 1, 8'h00, 8'h20, 0, 5);
        add("s_idle",  0, 8'h00, 1, 8'h00, 8'h00, 0, 5);
        add("bp_gnt",  0, 8'h08, 0, 8'h08, 8'h00, 1, 3);
        for (int i = 0; i < 5; i++) begin
            add("bp_hold", 0, 8'h08, 0, 8'h08, 8'h00, 1, 3);
        end
        add("bp_ack",  0, 8'h08, 1, 8'h00, 8'h08, 0, 3);
        add("bp_idle", 0, 8'h00, 1, 8'h00, 8'h00, 0, 3);
        add("dr_gnt",  0, 8'h04, 0, 8'h04, 8'h00, 1, 2);
        add("dr_hold", 0, 8'h00, 0, 8'h04, 8'h00, 1, 2);
        add("dr_ack",  0, 8'h00, 1, 8'h00, 8'h04, 0, 2);
        add("rm_gnt",  0, 8'h40, 0, 8'h40, 8'h00, 1, 6);
        add("rm_rst",  1, 8'h40, 1, 8'h00, 8'h00, 0, 0);
        add("rm_gnt0", 0, 8'h41, 0, 8'h01, 8'h00, 1, 0);
        add("rm_ack",  0, 8'h41, 1, 8'h00, 8'h01, 0, 0);

        foreach (tbl[i]) begin
            reset     = tbl[i].rst;
            req       = tbl[i].req;
            out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk({tbl[i].name, "_grant"}, 16'(grant), 16'(tbl[i].e_grant));
            chk({tbl[i].name, "_ack"}, 16'(ack), 16'(tbl[i].e_ack));
            chk({tbl[i].name, "_valid"}, 16'(out_valid), 16'(tbl[i].e_valid));
            chk({tbl[i].name, "_sel"}, 16'(sel), 16'(tbl[i].e_sel));
            chk({tbl[i].name, "_overlap"}, 16'(grant & ack), 16'h0000);
            if (tbl[i].e_valid) begin
                chk({tbl[i].name, "_out"}, out, words[tbl[i].e_sel]);
            end
        end

        // All eight requesting from reset: acks must rotate 0..7 twice.
        reset = 1'b1; req = 8'hFF; out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        nacks   = 0;
        exp_idx = 0;
        for (int c = 0; c < 40 && nacks < 16; c++) begin
            @(posedge clk);
            #1;
            if (ack != 8'h00) begin
                exp_ack = 8'h01 << exp_idx;
                chk("fair_order", 16'(ack), 16'(exp_ack));
                exp_idx = (exp_idx + 1) % 8;
                nacks++;
            end
        end
        chk("fair_count", 16'(nacks), 16'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
